m62_rom_dl_sched: RTL and testbench
===================================

// Module: m62_rom_dl_sched
// PURPOSE
//  Sequences the MRA ROM download stream from hps_io into the M62 memory system.
//  Each ioctl byte is decoded by address region and steered to:
//   - SDRAM port1 (CPU image, every byte) and port2 (sprite copy, addr>=SP_BASE),
//     using toggle req/ack handshakes; unlike a fire-and-forget toggle, it waits for both acks;
//   - the sound-ROM dpram;
//   - the PROM loader.
//  Applies backpressure (dl_wait) and owns rom_loaded and the core reset stretcher.
// PARAMETERS
//  SND_BASE    25'h20000  first sound-ROM byte (dpram region start)
//  SND_END     25'h30000  first byte past sound ROM
//  SP_BASE     25'h30000  first byte also mirrored to SDRAM port2 (port2 addr = dl_addr-SP_BASE)
//  PROM_BASE   25'hA0000  first colour/height PROM byte
//  PROM_END    25'hA0920  first byte past PROMs
//  RST_CYCLES  16'hFFFF   core reset stretch length in clk_sys cycles
//  ACK_TMO     8'd255     max cycles waiting for SDRAM acks before abort
// PORTS
//  clk_sys     in   1   system clock (24 MHz domain of hps_io)
//  reset_n     in   1   asynchronous active-low reset
//  dl_active   in   1   ioctl_download & index==0
//  dl_wr       in   1   ioctl_wr (level; edge-detected here)
//  dl_addr     in   25  ioctl_addr
//  dl_data     in   8   ioctl_dout
//  user_rst    in   1   OSD reset | button reset
//  dl_wait     out  1   high while a byte is in flight; HPS must hold next dl_wr
//  p1_req      out  1   port1 toggle request;  p1_ack in 1 (done when ack==req)
//  p1_a/ds/d   out  23/2/16  word addr, byte lanes {a[0],~a[0]}, {data,data}
//  p2_req      out  1   port2 toggle request;  p2_ack in 1
//  p2_a/ds/d   out  23/2/16  same encoding on (dl_addr-SP_BASE)
//  snd_we      out  1   1-cycle dpram write strobe; snd_addr out 16, snd_d out 8
//  prom_we     out  1   1-cycle PROM write strobe;  prom_addr out 12 (dl_addr-PROM_BASE), prom_d out 8
//  rom_loaded  out  1   sticky: first complete download finished
//  core_reset  out  1   active-high reset to target_top/hiscore
//  dl_err      out  1   sticky: ack timeout or overrun
// BEHAVIOUR
//  Reset values (reset_n=0): all outputs 0 except core_reset=1; p*_req=0; FSM=IDLE; counter=RST_CYCLES.
//  Write detect: a write event is dl_wr rising (registered dl_wr_q) with dl_active=1.
//  FSM IDLE -> ISSUE on a write event. The event cycle is the same cycle as the latch of
//   addr/data (registered outputs).
//  ISSUE (1 cycle):
//   - toggle p1_req;
//   - toggle p2_req iff addr>=SP_BASE;
//   - pulse snd_we iff SND_BASE<=addr<SND_END;
//   - pulse prom_we iff PROM_BASE<=addr<PROM_END;
//   - go to WAIT.
//  WAIT: exit to IDLE when p1_ack==p1_req and (no p2 issued or p2_ack==p2_req).
//   - Timeout: tmo counter reaches ACK_TMO -> set dl_err, go to IDLE; req levels are left as-is.
//  dl_wait = (state!=IDLE). Latency from the event cycle: ISSUE is 1 cycle after, WAIT is 2 cycles
//   after; minimum busy time is 3 cycles.
//  Overrun: a write event while state!=IDLE sets dl_err; that byte is dropped and no req toggles.
//  dl_active falls during WAIT: the transaction completes normally.
//   - rom_loaded is set on the first cycle with dl_active=0 AND state==IDLE after a download.
//  rom_loaded clears only on reset_n.
//  Reset stretcher:
//   - counter<=RST_CYCLES whenever user_rst | ~rom_loaded | dl_active;
//   - otherwise it decrements to 0 and holds;
//   - core_reset = (counter!=0), registered.
//  Address arithmetic is 25-bit unsigned. Below-base subtraction wraps, but the outputs are
//   gated by the region compare, so the wrap is harmless.
// STRUCTURE
//  m62_dl_pkg: region constants, state enum {IDLE,ISSUE,WAIT}, port-addr helper function.
//  Sub-module m62_reset_stretch (counter + rom_loaded edge logic); FSM/decode stays top-level.
// TESTING
//  1. Write 0x5A @0x00001, acks echo after 4 clk:
//     -> p1_a=0, p1_ds=2'b10, p1_d=0x5A5A; p1_req toggles; p2 untouched; dl_wait high 6 clk.
//  2. Write @0x30000 -> p1 and p2 both toggle, p2_a=0.
//     Delay p2_ack by 10 clk -> dl_wait stays high until p2_ack matches.
//  3. Write @0x2ABCD -> snd_we single pulse, snd_addr=0xABCD.
//     Write @0xA0905 -> prom_we, prom_addr=0x905.
//  4. Second dl_wr edge while WAIT -> dl_err=1, no extra p1 toggle.
//     Withhold acks 256 clk -> dl_err, FSM back to IDLE.
//  5. Drop dl_active mid-WAIT -> rom_loaded rises only after the ack.
//     core_reset falls exactly RST_CYCLES+1 clk after dl_active falls; pulse user_rst -> reload.
//  6. Assert reset_n low mid-WAIT -> immediate IDLE, core_reset=1, rom_loaded=0, dl_wait=0.

Source files
------------

// File: rtl/m62_dl_pkg.sv
// Shared constants, FSM state type and SDRAM port address helper for the
// M62 ROM download scheduler.
package m62_dl_pkg;

  localparam logic [24:0] SND_BASE   = 25'h0020000;
  localparam logic [24:0] SND_END    = 25'h0030000;
  localparam logic [24:0] SP_BASE    = 25'h0030000;
  localparam logic [24:0] PROM_BASE  = 25'h00A0000;
  localparam logic [24:0] PROM_END   = 25'h00A0920;
  localparam logic [15:0] RST_CYCLES = 16'hFFFF;
  localparam logic [7:0]  ACK_TMO    = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
  } port_addr_t;

  // 16-bit SDRAM word address plus byte lanes selecting the addressed byte.
  function automatic port_addr_t port_addr(input logic [23:0] off);
    port_addr_t p;
    p.a  = off[23:1];
    p.ds = {off[0], ~off[0]};
    return p;
  endfunction

endpackage

// File: rtl/m62_rom_dl_sched_if.sv
// Download-side bus: ioctl byte stream in, SDRAM ports, sound dpram and
// PROM loader strobes out.
interface m62_rom_dl_sched_if;

  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;

  logic        p1_req;
  logic        p1_ack;
  logic [22:0] p1_a;
  logic [1:0]  p1_ds;
  logic [15:0] p1_d;

  logic        p2_req;
  logic        p2_ack;
  logic [22:0] p2_a;
  logic [1:0]  p2_ds;
  logic [15:0] p2_d;

  logic        snd_we;
  logic [15:0] snd_addr;
  logic [7:0]  snd_d;

  logic        prom_we;
  logic [11:0] prom_addr;
  logic [7:0]  prom_d;

  // Scheduler side.
  modport master (
    input  dl_active, dl_wr, dl_addr, dl_data, p1_ack, p2_ack,
    output dl_wait,
    output p1_req, p1_a, p1_ds, p1_d,
    output p2_req, p2_a, p2_ds, p2_d,
    output snd_we, snd_addr, snd_d,
    output prom_we, prom_addr, prom_d
  );

  // HPS / memory side.
  modport slave (
    output dl_active, dl_wr, dl_addr, dl_data, p1_ack, p2_ack,
    input  dl_wait,
    input  p1_req, p1_a, p1_ds, p1_d,
    input  p2_req, p2_a, p2_ds, p2_d,
    input  snd_we, snd_addr, snd_d,
    input  prom_we, prom_addr, prom_d
  );

endinterface

// File: rtl/m62_reset_stretch.sv
// Tracks completion of the first ROM download and holds the core in reset
// for RST_CYCLES after it (or after any user reset).
module m62_reset_stretch
  import m62_dl_pkg::*;
(
  input  logic clk_sys,
  input  logic reset_n,
  input  logic dl_active,
  input  logic user_rst,
  input  logic fsm_idle,
  output logic rom_loaded,
  output logic core_reset
);

  logic        dl_seen_q, dl_seen_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic [15:0] cnt_q, cnt_d;
  logic        core_reset_q, core_reset_d;

  always_comb begin
    dl_seen_d    = dl_seen_q | dl_active;
    rom_loaded_d = rom_loaded_q | (dl_seen_q & ~dl_active & fsm_idle);
    if (user_rst | ~rom_loaded_q | dl_active) begin
      cnt_d = RST_CYCLES;
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // Looking at the next count lets core_reset drop on the same edge the counter empties.
    core_reset_d = (cnt_d != 16'd0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_seen_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      cnt_q        <= RST_CYCLES;
      core_reset_q <= 1'b1;
    end else begin
      dl_seen_q    <= dl_seen_d;
      rom_loaded_q <= rom_loaded_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule

// File: rtl/m62_rom_dl_sched.sv
// Steers each ioctl download byte to SDRAM port1/port2, sound dpram or the
// PROM loader, and holds off the HPS until both SDRAM acks return.
//   state | meaning
//   IDLE  | waiting for a dl_wr rising edge; address/data latched on the event
//   ISSUE | one cycle: toggle requests, fire dpram/PROM strobes
//   WAIT  | waiting for port acks, bounded by the ack timeout
module m62_rom_dl_sched
  import m62_dl_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 user_rst,
  m62_rom_dl_sched_if.master   bus,
  output logic                 rom_loaded,
  output logic                 core_reset,
  output logic                 dl_err
);

  state_e      state_q, state_d;
  logic        dl_wr_q;
  logic        wr_evt;
  logic        acks_done;
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;

  logic        hit_sp_q, hit_sp_d;
  logic        hit_snd_q, hit_snd_d;
  logic        hit_prom_q, hit_prom_d;
  port_addr_t  p1_pa_q, p1_pa_d;
  port_addr_t  p2_pa_q, p2_pa_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] snd_addr_q, snd_addr_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic        p1_req_q, p1_req_d;
  logic        p2_req_q, p2_req_d;
  logic        p1_ack_q, p2_ack_q;
  logic        snd_we_q, snd_we_d;
  logic        prom_we_q, prom_we_d;

  assign wr_evt    = bus.dl_wr & ~dl_wr_q & bus.dl_active;
  assign acks_done = (p1_ack_q == p1_req_q) && (!hit_sp_q || (p2_ack_q == p2_req_q));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmo_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (wr_evt) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = ACK_TMO;
      end
      WAIT: begin
        if (acks_done) begin
          state_d = IDLE;
        end else if (tmo_q == 8'd0) begin
          // Requests are left toggled; a late ack simply realigns the levels.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_evt && (state_q != IDLE)) err_d = 1'b1;
  end

  always_comb begin
    hit_sp_d    = hit_sp_q;
    hit_snd_d   = hit_snd_q;
    hit_prom_d  = hit_prom_q;
    p1_pa_d     = p1_pa_q;
    p2_pa_d     = p2_pa_q;
    byte_d      = byte_q;
    snd_addr_d  = snd_addr_q;
    prom_addr_d = prom_addr_q;
    p1_req_d    = p1_req_q;
    p2_req_d    = p2_req_q;
    snd_we_d    = 1'b0;
    prom_we_d   = 1'b0;
    if ((state_q == IDLE) && wr_evt) begin
      hit_sp_d    = (bus.dl_addr >= SP_BASE);
      hit_snd_d   = (bus.dl_addr >= SND_BASE) && (bus.dl_addr < SND_END);
      hit_prom_d  = (bus.dl_addr >= PROM_BASE) && (bus.dl_addr < PROM_END);
      p1_pa_d     = port_addr(bus.dl_addr[23:0]);
      p2_pa_d     = port_addr(bus.dl_addr[23:0] - SP_BASE[23:0]);
      byte_d      = bus.dl_data;
      snd_addr_d  = bus.dl_addr[15:0] - SND_BASE[15:0];
      prom_addr_d = bus.dl_addr[11:0] - PROM_BASE[11:0];
    end
    if (state_q == ISSUE) begin
      p1_req_d  = ~p1_req_q;
      if (hit_sp_q) p2_req_d = ~p2_req_q;
      snd_we_d  = hit_snd_q;
      prom_we_d = hit_prom_q;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_wr_q     <= 1'b0;
      hit_sp_q    <= 1'b0;
      hit_snd_q   <= 1'b0;
      hit_prom_q  <= 1'b0;
      p1_pa_q     <= '0;
      p2_pa_q     <= '0;
      byte_q      <= 8'd0;
      snd_addr_q  <= 16'd0;
      prom_addr_q <= 12'd0;
      p1_req_q    <= 1'b0;
      p2_req_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p2_ack_q    <= 1'b0;
      snd_we_q    <= 1'b0;
      prom_we_q   <= 1'b0;
    end else begin
      dl_wr_q     <= bus.dl_wr;
      hit_sp_q    <= hit_sp_d;
      hit_snd_q   <= hit_snd_d;
      hit_prom_q  <= hit_prom_d;
      p1_pa_q     <= p1_pa_d;
      p2_pa_q     <= p2_pa_d;
      byte_q      <= byte_d;
      snd_addr_q  <= snd_addr_d;
      prom_addr_q <= prom_addr_d;
      p1_req_q    <= p1_req_d;
      p2_req_q    <= p2_req_d;
      p1_ack_q    <= bus.p1_ack;
      p2_ack_q    <= bus.p2_ack;
      snd_we_q    <= snd_we_d;
      prom_we_q   <= prom_we_d;
    end
  end

  assign bus.dl_wait   = (state_q != IDLE);
  assign bus.p1_req    = p1_req_q;
  assign bus.p1_a      = p1_pa_q.a;
  assign bus.p1_ds     = p1_pa_q.ds;
  assign bus.p1_d      = {byte_q, byte_q};
  assign bus.p2_req    = p2_req_q;
  assign bus.p2_a      = p2_pa_q.a;
  assign bus.p2_ds     = p2_pa_q.ds;
  assign bus.p2_d      = {byte_q, byte_q};
  assign bus.snd_we    = snd_we_q;
  assign bus.snd_addr  = snd_addr_q;
  assign bus.snd_d     = byte_q;
  assign bus.prom_we   = prom_we_q;
  assign bus.prom_addr = prom_addr_q;
  assign bus.prom_d    = byte_q;
  assign dl_err        = err_q;

  m62_reset_stretch u_reset_stretch (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dl_active  (bus.dl_active),
    .user_rst   (user_rst),
    .fsm_idle   (state_q == IDLE),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset)
  );

endmodule

// File: tb/tb_m62_rom_dl_sched.sv
// Randomized and directed bench for the ROM download scheduler against a
// transaction-level model of regions, handshakes, timeouts and reset timing.
module tb_m62_rom_dl_sched;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic user_rst;
  logic rom_loaded;
  logic core_reset;
  logic dl_err;

  m62_rom_dl_sched_if bus();

  m62_rom_dl_sched dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .user_rst   (user_rst),
    .bus        (bus),
    .rom_loaded (rom_loaded),
    .core_reset (core_reset),
    .dl_err     (dl_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_mis = 0;
  bit m_p1_req, m_p2_req, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.dl_wr   = 1'b0;
    bus.p1_ack  = 1'b0;
    bus.p2_ack  = 1'b0;
    m_p1_req    = 1'b0;
    m_p2_req    = 1'b0;
    m_err       = 1'b0;
    #23;
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  // d1/d2: cycles after the request becomes visible before the ack is echoed;
  // negative means the ack is withheld.
  task automatic do_write(input logic [24:0] a, input logic [7:0] d, input int d1, input int d2,
                          input bit overrun, input bit drop_active);
    bit sp, snd, prom, tmo_exp, done, early;
    bit exp_p1, exp_p2;
    int busy, exp_busy, n_snd, n_prom, mx;
    logic [24:0] off2;
    sp     = (a >= 25'h30000);
    snd    = (a >= 25'h20000) && (a < 25'h30000);
    prom   = (a >= 25'hA0000) && (a < 25'hA0920);
    exp_p1 = ~m_p1_req;
    exp_p2 = sp ? ~m_p2_req : m_p2_req;
    tmo_exp = (d1 < 0) || (d1 > 254) || (sp && ((d2 < 0) || (d2 > 254)));
    mx = (sp && d2 > d1) ? d2 : d1;
    exp_busy = tmo_exp ? 257 : 3 + mx;
    off2 = a - 25'h30000;
    busy = 0; n_snd = 0; n_prom = 0; done = 0; early = 0;
    @(posedge clk_sys); #1;
    bus.dl_wr = 1'b1; bus.dl_addr = a; bus.dl_data = d;
    for (int n = 1; n <= 400 && !done; n++) begin
      @(posedge clk_sys); #1;
      if (n == 1) begin
        bus.dl_wr = 1'b0;
        check_eq("p1_a", bus.p1_a, (a >> 1) & 25'h7FFFFF);
        check_eq("p1_ds", bus.p1_ds, a[0] ? 2'b10 : 2'b01);
        check_eq("p1_d", bus.p1_d, {d, d});
        check_eq("p2_a", bus.p2_a, (off2 >> 1) & 25'h7FFFFF);
        check_eq("p2_ds", bus.p2_ds, off2[0] ? 2'b10 : 2'b01);
        check_eq("snd_addr", bus.snd_addr, (a - 25'h20000) & 25'hFFFF);
        check_eq("prom_addr", bus.prom_addr, (a - 25'hA0000) & 25'hFFF);
      end
      if (bus.snd_we) n_snd++;
      if (bus.prom_we) n_prom++;
      if (bus.dl_wait && rom_loaded && drop_active) early = 1;
      if (!bus.dl_wait) done = 1;
      else busy++;
      if (overrun && n == 3) bus.dl_wr = 1'b1;
      if (overrun && n == 4) bus.dl_wr = 1'b0;
      if (drop_active && n == 3) bus.dl_active = 1'b0;
      if (d1 >= 0 && n - 2 == d1) bus.p1_ack = exp_p1;
      if (sp && d2 >= 0 && n - 2 == d2) bus.p2_ack = exp_p2;
    end
    m_err = m_err | tmo_exp | overrun;
    check_eq("busy_cycles", busy, exp_busy);
    check_eq("p1_req", bus.p1_req, exp_p1);
    check_eq("p2_req", bus.p2_req, exp_p2);
    check_eq("snd_we_pulses", n_snd, snd);
    check_eq("prom_we_pulses", n_prom, prom);
    check_eq("dl_err", dl_err, m_err);
    if (drop_active) begin
      check_eq("rom_loaded_early", early, 0);
      check_eq("rom_loaded_at_idle", rom_loaded, 0);
    end
    m_p1_req = exp_p1;
    m_p2_req = exp_p2;
    bus.p1_ack = exp_p1;
    bus.p2_ack = exp_p2;
  endtask

  initial begin
    logic [24:0] ra;
    logic [24:0] bnd [8];
    int fall;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    bus.p1_ack    = 1'b0;
    bus.p2_ack    = 1'b0;
    user_rst      = 1'b0;
    reset_n       = 1'b0;
    #12;
    check_eq("rst_dl_wait", bus.dl_wait, 0);
    check_eq("rst_p1_req", bus.p1_req, 0);
    check_eq("rst_p2_req", bus.p2_req, 0);
    check_eq("rst_p1_ds", bus.p1_ds, 0);
    check_eq("rst_p2_a", bus.p2_a, 0);
    check_eq("rst_snd_we", bus.snd_we, 0);
    check_eq("rst_prom_we", bus.prom_we, 0);
    check_eq("rst_rom_loaded", rom_loaded, 0);
    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_dl_err", dl_err, 0);
    do_reset();
    bus.dl_active = 1'b1;

    do_write(25'h00001, 8'h5A, 3, 0, 0, 0);
    do_write(25'h30000, 8'hC3, 0, 10, 0, 0);
    do_write(25'h2ABCD, 8'h11, 1, 0, 0, 0);
    do_write(25'hA0905, 8'h22, 2, 2, 0, 0);

    bnd = '{25'h1FFFF, 25'h20000, 25'h2FFFF, 25'h30001,
            25'h9FFFF, 25'hA0000, 25'hA091F, 25'hA0920};
    foreach (bnd[i]) do_write(bnd[i], 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4), 0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 25'($urandom_range(0, 32'h1FFFF));
        1: ra = 25'($urandom_range(32'h20000, 32'h2FFFF));
        2: ra = 25'($urandom_range(32'h30000, 32'h9FFFF));
        3: ra = 25'($urandom_range(32'hA0000, 32'hA091F));
        default: ra = 25'($urandom_range(32'hA0920, 32'h1FFFFFF));
      endcase
      do_write(ra, 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), 0, 0);
    end

    do_write(25'h00100, 8'h33, 254, 0, 0, 0);
    do_write(25'h00010, 8'h44, -1, -1, 0, 0);

    do_reset();
    do_write(25'h00200, 8'h55, 5, 5, 1, 0);

    do_reset();
    do_write(25'h40002, 8'h66, 6, 6, 0, 1);
    fall = 0;
    for (int k = 1; k <= 70000 && fall == 0; k++) begin
      @(posedge clk_sys); #1;
      if (k == 1) check_eq("rom_loaded_set", rom_loaded, 1);
      if (!core_reset) fall = k;
    end
    check_eq("core_reset_fall", fall, 32'd65536);

    @(posedge clk_sys); #1;
    bus.dl_wr = 1'b1;
    fall = 0;
    repeat (3) begin
      @(posedge clk_sys); #1;
      if (bus.dl_wait) fall++;
    end
    bus.dl_wr = 1'b0;
    check_eq("inactive_wr_busy", fall, 0);
    check_eq("inactive_wr_p1_req", bus.p1_req, m_p1_req);

    user_rst = 1'b1;
    @(posedge clk_sys); #1;
    user_rst = 1'b0;
    check_eq("user_rst_reload", core_reset, 1);
    repeat (5) @(posedge clk_sys);
    #1;
    check_eq("user_rst_hold", core_reset, 1);
    check_eq("rom_loaded_sticky", rom_loaded, 1);

    bus.dl_active = 1'b1;
    bus.dl_wr = 1'b1; bus.dl_addr = 25'h40000;
    @(posedge clk_sys); #1;
    bus.dl_wr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    check_eq("pre_rst_wait", bus.dl_wait, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_dl_wait", bus.dl_wait, 0);
    check_eq("async_core_reset", core_reset, 1);
    check_eq("async_rom_loaded", rom_loaded, 0);
    check_eq("async_p1_req", bus.p1_req, 0);
    check_eq("async_p2_req", bus.p2_req, 0);
    check_eq("async_dl_err", dl_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
